// File: rtl/mem_arbiter.sv
// IFU/LSU arbiter sharing one memory port, locked to the owner until its response returns.
// Build option ARB_ROUND_ROBIN_EN: alternate the grant on contention instead of LSU priority.
module mem_arbiter #(
  parameter int TIMEOUT = 0,
  parameter int CW      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IFU = 2'd1,
    BUSY_LSU = 2'd2
  } state_t;

  localparam logic G_IFU = 1'b0;
  localparam logic G_LSU = 1'b1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);
  localparam logic WD_EN = (TIMEOUT > 0);

  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [CW-1:0] tcnt, tcnt_nxt;
  logic          terr_nxt;
  logic          any_req;
  logic          win_lsu;
  logic          busy;
  logic          tmo;

  assign any_req = ifu_reqValid | lsu_reqValid;
  assign busy    = (state != IDLE);
  assign tmo     = WD_EN & busy & ~mem_respValid
                 & (tcnt == TLIM);

  always_comb begin
    win_lsu = lsu_reqValid;
`ifdef ARB_ROUND_ROBIN_EN
    if (ifu_reqValid && lsu_reqValid)
      win_lsu = (last_grant == G_IFU);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= G_LSU;
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      tcnt        <= tcnt_nxt;
      timeout_err <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    tcnt_nxt       = tcnt;
    terr_nxt       = timeout_err;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          last_grant_nxt = win_lsu ? G_LSU : G_IFU;
          tcnt_nxt       = '0;
          if (!mem_respValid)
            state_nxt = win_lsu ? BUSY_LSU : BUSY_IFU;
        end
      end
      BUSY_IFU, BUSY_LSU: begin
        if (mem_respValid) begin
          state_nxt = IDLE;
        end else if (tmo) begin
          state_nxt = IDLE;
          terr_nxt  = 1'b1;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Watchdog off: keep its state pinned so it is optimised away.
    if (!WD_EN) begin
      tcnt_nxt = '0;
      terr_nxt = 1'b0;
    end
  end

  always_comb begin
    logic        own_lsu;
    logic        active;
    logic        done;
    logic [31:0] rd;
    own_lsu       = 1'b0;
    active        = 1'b0;
    done          = 1'b0;
    rd            = '0;
    mem_reqValid  = 1'b0;
    mem_addr      = '0;
    mem_wen       = 1'b0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    ifu_respValid = 1'b0;
    ifu_rdata     = '0;
    lsu_respValid = 1'b0;
    lsu_rdata     = '0;
    unique case (state)
      IDLE: begin
        active  = any_req;
        own_lsu = win_lsu;
      end
      BUSY_IFU: begin
        active  = 1'b1;
        own_lsu = 1'b0;
      end
      BUSY_LSU: begin
        active  = 1'b1;
        own_lsu = 1'b1;
      end
      default: active = 1'b0;
    endcase
    if (active) begin
      mem_reqValid = 1'b1;
      if (own_lsu) begin
        mem_addr  = lsu_addr;
        mem_wen   = lsu_wen;
        mem_wdata = lsu_wdata;
        mem_wmask = lsu_wmask;
      end else begin
        mem_addr  = ifu_addr;
      end
    end
    done = (active & mem_respValid) | tmo;
    rd   = tmo ? 32'hDEAD_BEEF : mem_rdata;
    if (done) begin
      if (own_lsu) begin
        lsu_respValid = 1'b1;
        lsu_rdata     = rd;
      end else begin
        ifu_respValid = 1'b1;
        ifu_rdata     = rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus contention,
// watchdog and reset sequences.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  logic        timeout_err;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.TIMEOUT(5), .CW(8)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
    .mem_reqValid(mem_reqValid), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        lreq;
    logic [31:0] laddr;
    logic        lwen;
    logic [31:0] lwd;
    logic [3:0]  lwm;
    logic        mresp;
    logic [31:0] mrd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [31:0] e_wd;
    logic [3:0]  e_wm;
    logic        e_iv;
    logic [31:0] e_ird;
    logic        e_lv;
    logic [31:0] e_lrd;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic clr_in();
    ifu_reqValid  = 1'b0;
    ifu_addr      = '0;
    lsu_reqValid  = 1'b0;
    lsu_addr      = '0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    mem_respValid = 1'b0;
    mem_rdata     = '0;
  endtask

  logic exp_lsu[4];
  logic [31:0] ea;

  initial begin
    tbl[0]  = '{0,0,0,0,0,0,0,0,0,
                0,0,0,0,0,0,0,0,0};
    tbl[1]  = '{1,32'h8000_0000,0,0,0,0,0,0,0,
                1,32'h8000_0000,0,0,0,0,0,0,0};
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = '{1,32'h8000_0000,0,0,0,0,0,1,32'h13,
                1,32'h8000_0000,0,0,0,1,32'h13,0,0};
    tbl[5]  = tbl[0];
    tbl[6]  = '{0,0,1,32'h1000,1,32'hCAFE_BABE,4'b0011,
                1,32'h5A5A,
                1,32'h1000,1,32'hCAFE_BABE,4'b0011,
                0,0,1,32'h5A5A};
    tbl[7]  = '{0,0,0,0,0,0,0,1,32'h77,
                0,0,0,0,0,0,0,0,0};
    tbl[8]  = '{1,32'h400,0,0,0,0,0,0,0,
                1,32'h400,0,0,0,0,0,0,0};
    tbl[9]  = '{1,32'h400,1,32'h500,1,32'h1122_3344,4'hF,
                0,0,
                1,32'h400,0,0,0,0,0,0,0};
    tbl[10] = '{1,32'h400,1,32'h500,1,32'h1122_3344,4'hF,
                1,32'hAAAA,
                1,32'h400,0,0,0,1,32'hAAAA,0,0};
    tbl[11] = '{0,0,1,32'h500,1,32'h1122_3344,4'hF,0,0,
                1,32'h500,1,32'h1122_3344,4'hF,0,0,0,0};
    tbl[12] = '{0,0,1,32'h500,1,32'h1122_3344,4'hF,
                1,32'h1234,
                1,32'h500,1,32'h1122_3344,4'hF,
                0,0,1,32'h1234};
    tbl[13] = tbl[0];

`ifdef ARB_ROUND_ROBIN_EN
    exp_lsu = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    clr_in();
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("rst mem_req", 32'(mem_reqValid), 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst ifu_resp", 32'(ifu_respValid), 0);
    chk("rst lsu_resp", 32'(lsu_respValid), 0);
    chk("rst terr", 32'(timeout_err), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      ifu_reqValid  = tbl[i].ireq;
      ifu_addr      = tbl[i].iaddr;
      lsu_reqValid  = tbl[i].lreq;
      lsu_addr      = tbl[i].laddr;
      lsu_wen       = tbl[i].lwen;
      lsu_wdata     = tbl[i].lwd;
      lsu_wmask     = tbl[i].lwm;
      mem_respValid = tbl[i].mresp;
      mem_rdata     = tbl[i].mrd;
      #1;
      chk($sformatf("v%0d mem_req", i),
          32'(mem_reqValid), 32'(tbl[i].e_req));
      chk($sformatf("v%0d mem_addr", i),
          mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d mem_wen", i),
          32'(mem_wen), 32'(tbl[i].e_wen));
      chk($sformatf("v%0d mem_wdata", i),
          mem_wdata, tbl[i].e_wd);
      chk($sformatf("v%0d mem_wmask", i),
          32'(mem_wmask), 32'(tbl[i].e_wm));
      chk($sformatf("v%0d ifu_resp", i),
          32'(ifu_respValid), 32'(tbl[i].e_iv));
      chk($sformatf("v%0d ifu_rdata", i),
          ifu_rdata, tbl[i].e_ird);
      chk($sformatf("v%0d lsu_resp", i),
          32'(lsu_respValid), 32'(tbl[i].e_lv));
      chk($sformatf("v%0d lsu_rdata", i),
          lsu_rdata, tbl[i].e_lrd);
    end

    // Contention: both keep requesting through every grant.
    for (int g = 0; g < 4; g++) begin
      @(negedge clock);
      clr_in();
      ifu_reqValid = 1'b1;
      ifu_addr     = 32'h600;
      lsu_reqValid = 1'b1;
      lsu_addr     = 32'h700;
      #1;
      ea = exp_lsu[g] ? 32'h700 : 32'h600;
      chk($sformatf("arb%0d grant addr", g), mem_addr, ea);
      chk($sformatf("arb%0d mem_req", g),
          32'(mem_reqValid), 1);
      @(negedge clock);
      mem_respValid = 1'b1;
      mem_rdata     = 32'h100 + g;
      #1;
      chk($sformatf("arb%0d locked addr", g), mem_addr, ea);
      chk($sformatf("arb%0d lsu_resp", g),
          32'(lsu_respValid), 32'(exp_lsu[g]));
      chk($sformatf("arb%0d ifu_resp", g),
          32'(ifu_respValid), 32'(!exp_lsu[g]));
      chk($sformatf("arb%0d rdata", g),
          exp_lsu[g] ? lsu_rdata : ifu_rdata, 32'h100 + g);
    end
    @(negedge clock);
    lsu_reqValid  = 1'b0;
    mem_respValid = 1'b0;
    #1;
    chk("after lsu ifu grant", mem_addr, 32'h600);
    @(negedge clock);
    mem_respValid = 1'b1;
    mem_rdata     = 32'h66;
    #1;
    chk("after lsu ifu resp", ifu_rdata, 32'h66);

    // Real response in the timeout cycle beats the watchdog.
    @(negedge clock);
    clr_in();
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h900;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      #1;
      chk($sformatf("tmoA busy%0d ifu_resp", c + 1),
          32'(ifu_respValid), 0);
    end
    @(negedge clock);
    mem_respValid = 1'b1;
    mem_rdata     = 32'h42;
    #1;
    chk("tmoA real rdata", ifu_rdata, 32'h42);
    @(negedge clock);
    clr_in();
    #1;
    chk("tmoA terr clear", 32'(timeout_err), 0);

    // Memory never answers: abort on the 6th busy cycle.
    @(negedge clock);
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'hA00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      #1;
      chk($sformatf("tmoB busy%0d ifu_resp", c + 1),
          32'(ifu_respValid), 0);
      chk($sformatf("tmoB busy%0d terr", c + 1),
          32'(timeout_err), 0);
    end
    @(negedge clock);
    #1;
    chk("tmoB ifu_resp", 32'(ifu_respValid), 1);
    chk("tmoB ifu_rdata", ifu_rdata, 32'hDEAD_BEEF);
    chk("tmoB lsu_resp", 32'(lsu_respValid), 0);
    @(negedge clock);
    clr_in();
    #1;
    chk("tmoB terr set", 32'(timeout_err), 1);
    chk("tmoB idle", 32'(mem_reqValid), 0);
    @(negedge clock);
    #1;
    chk("tmoB terr sticky", 32'(timeout_err), 1);

    // Reset in the middle of a busy transaction.
    @(negedge clock);
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'hB00;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    clr_in();
    #1;
    chk("midrst terr", 32'(timeout_err), 0);
    chk("midrst mem_req", 32'(mem_reqValid), 0);
    @(negedge clock);
    reset         = 1'b0;
    mem_respValid = 1'b1;
    mem_rdata     = 32'h99;
    #1;
    chk("stray ifu_resp", 32'(ifu_respValid), 0);
    chk("stray lsu_resp", 32'(lsu_respValid), 0);
    chk("stray mem_req", 32'(mem_reqValid), 0);
    @(negedge clock);
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'hC00;
    mem_rdata    = 32'h33;
    #1;
    chk("post rst zero-lat resp", 32'(ifu_respValid), 1);
    chk("post rst rdata", ifu_rdata, 32'h33);
    @(negedge clock);
    clr_in();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
